// File: rtl/cnt_rd_pkg.sv
// Shared types and defaults for the count-sample reader FIFO.
// Optional duplicate-drop feature is enabled by CNT_SAMPLE_READER_DUP_DROP_EN.
package cnt_rd_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } rd_state_t;

    localparam int DEF_DW    = 4;
    localparam int DEF_DEPTH = 4;

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cnt_rd_mem.sv
// DEPTH x DW sample storage: one synchronous write port, one asynchronous read port.
// Storage is deliberately not reset; the top masks rd_data while empty.
module cnt_rd_mem #(
    parameter int DW    = 4,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cnt_sample_reader.sv
// Buffers count samples from a wr_en producer and presents them on a show-ahead
// valid/ready port with level, full and sticky overflow. Define
// CNT_SAMPLE_READER_DUP_DROP_EN to discard back-to-back duplicate samples.
module cnt_sample_reader
    import cnt_rd_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    localparam int LW   = lvl_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          overflow,
`ifdef CNT_SAMPLE_READER_DUP_DROP_EN
    output logic [7:0]    dup_cnt,
`endif
    input  logic          ovf_clr
);

    localparam int AW = $clog2(DEPTH);

    rd_state_t     state_q, state_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          pop, push, drop, dup;
    logic [DW-1:0] mem_rdata;

    // Empty state ignores rd_ready; a full FIFO still accepts a write if it pops.
    assign pop  = (state_q != EMPTY) && rd_ready;
    assign push = wr_en && !dup && ((state_q != FULL) || pop);
    assign drop = wr_en && !dup && (state_q == FULL) && !pop;

`ifdef CNT_SAMPLE_READER_DUP_DROP_EN
    logic [DW-1:0] last_wr_q;
    logic          last_vld_q;
    logic [7:0]    dup_cnt_q;

    assign dup = wr_en && last_vld_q && (wr_data == last_wr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr_q  <= '0;
            last_vld_q <= 1'b0;
            dup_cnt_q  <= '0;
        end else begin
            if (push) begin
                last_wr_q  <= wr_data;
                last_vld_q <= 1'b1;
            end
            if (dup && (dup_cnt_q != 8'hFF)) begin
                dup_cnt_q <= dup_cnt_q + 8'd1;
            end
        end
    end

    assign dup_cnt = dup_cnt_q;
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        ovf_d   = ovf_q;

        case (state_q)
            EMPTY:   if (push) state_d = ACTIVE;
            ACTIVE: begin
                if (push && !pop && (level_q == LW'(DEPTH - 1))) begin
                    state_d = FULL;
                end else if (pop && !push && (level_q == LW'(1))) begin
                    state_d = EMPTY;
                end
            end
            FULL:    if (pop && !push) state_d = ACTIVE;
            default: state_d = EMPTY;
        endcase

        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end

        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (pop)  rptr_d = rptr_q + AW'(1);
        if (push) wptr_d = wptr_q + AW'(1);

        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            level_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            ovf_q   <= ovf_d;
        end
    end

    cnt_rd_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr_q),
        .wdata (wr_data),
        .raddr (rptr_q),
        .rdata (mem_rdata)
    );

    assign rd_valid = (state_q != EMPTY);
    assign full     = (state_q == FULL);
    assign level    = level_q;
    assign overflow = ovf_q;
    assign rd_data  = rd_valid ? mem_rdata : '0;

endmodule

// File: doc/cnt_sample_reader.md
Name: cnt_sample_reader

Overview:
Consumer end of the enable-gated count-capture interface. A producer strobes wr_en with a count value. This block accepts and buffers the values in a small FIFO. It presents them downstream through a valid/ready read port, and reports fill state and overflow. It sits between count producers (gated counters, capture tasks) and checkers or loggers that drain at their own rate.

Parameters:
DW, 4, width of a count sample
DEPTH, 4, FIFO entries; power of two, ≥2
LW, $clog2(DEPTH+1), width of level output (derived, not overridable)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  producer strobe; sample wr_data this cycle
wr_data  in  DW  count value from producer
rd_ready  in  1  consumer can take rd_data this cycle
rd_valid  out  1  rd_data holds a buffered sample
rd_data  out  DW  oldest buffered sample (show-ahead)
level  out  LW  number of buffered samples, 0..DEPTH
full  out  1  level == DEPTH
overflow  out  1  sticky; a write was dropped because the FIFO was full
ovf_clr  in  1  synchronous clear of overflow

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values: rd_valid=0, rd_data=0, level=0, full=0, overflow=0. Pointers=0, state=EMPTY. Memory contents are don't-care but must read 0 on rd_data while empty.
- Read: pop happens when rd_valid && rd_ready at a rising edge.
  - rd_data is combinational from mem[rptr] (show-ahead).
  - rd_data is forced to 0 when rd_valid=0.
  - rd_data is stable while rd_valid=1 and rd_ready=0.
- Write: push happens when wr_en && (!full || pop) at a rising edge.
  - Write latency: data written at edge N is visible on rd_data after edge N, if the FIFO was empty.
- State machine (state held in a register; rd_valid and full decoded from it):
  - EMPTY: level=0.
  - ACTIVE: 0<level<DEPTH.
  - FULL: level=DEPTH.
- State transitions:
  - EMPTY→ACTIVE on push.
  - ACTIVE→FULL on push without pop when level==DEPTH-1.
  - ACTIVE→EMPTY on pop without push when level==1.
  - FULL→ACTIVE on pop without push.
  - Push and pop together: no state or level change.
- Boundary conditions:
  - Empty: rd_ready is ignored; no pop, no underflow.
  - Empty with wr_en: push only; rd_valid rises after the edge.
  - Full with wr_en and no pop: write dropped, overflow set to 1 at that edge, memory and pointers unchanged.
  - Full with wr_en and pop together: both occur; level stays DEPTH, no overflow.
- Overflow flag:
  - ovf_clr clears overflow.
  - If ovf_clr and a new drop coincide, set wins (overflow=1).
- Pointers: $clog2(DEPTH) bits each, wrapping modulo DEPTH. Level is tracked separately and is authoritative for full/empty.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Buffered samples are discarded. rd_valid falls without waiting for a clock edge.
- All outputs are registered except rd_data (memory read mux).

Optional Feature:
- Macro: CNT_SAMPLE_READER_DUP_DROP_EN.
- Defined:
  - The block keeps a last_wr register (reset 0) plus last_vld (reset 0).
  - A wr_en whose wr_data equals last_wr while last_vld=1 is discarded without push and without setting overflow.
  - Every accepted push updates last_wr and sets last_vld.
  - Output port dup_cnt (8 bits, saturating at 255, reset 0) counts discarded duplicates.
- Undefined: every wr_en is a push candidate. The dup_cnt port does not exist.

Decomposition:
- Package cnt_rd_pkg holds:
  - typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} rd_state_t
  - default DW and DEPTH localparams
  - function lvl_w(depth) returning $clog2(depth+1)
- Sub-module cnt_rd_mem: DEPTH×DW register array.
  - Write port: we, waddr, wdata.
  - Asynchronous read port: raddr → rdata.
  - No reset on the storage.
- Top level owns pointers, level, the state machine, overflow, and the optional dedup logic.

Test Plan:
1. Reset, then wr_en=1 with wr_data=2 for 1 cycle, rd_ready=0 → next cycle: rd_valid=1, rd_data=2, level=1, state ACTIVE.
2. Write 1,2,3,4 back-to-back with rd_ready=0, then write 5 → full=1, level=4, overflow=1. Then drain with rd_ready=1 → reads 1,2,3,4 in order, rd_valid falls after the 4th pop.
3. FIFO full holding 1..4; wr_en with value 9 and rd_ready=1 on the same edge → pop 1, push 9, level stays 4, overflow stays 0. Subsequent drain yields 2,3,4,9.
4. Empty FIFO with rd_ready=1 held for 5 cycles → no pop, level=0, rd_data=0. Then write 7 → rd_valid high and value 7 consumed on the following edge.
5. Overflow set, then ovf_clr pulse → overflow=0. Overflow set, then ovf_clr coincident with another drop → overflow remains 1.
6. With 3 entries buffered, assert rst_n=0 between clock edges → rd_valid, level, full and overflow go to 0 immediately. After release, the FIFO is empty. With CNT_SAMPLE_READER_DUP_DROP_EN defined, also write 3,3,3,4 → buffered 3,4, dup_cnt=2.
